synch_fifo_prog: RTL and testbench

//   Parametrised single-clock FIFO, successor to the basic synchronous FIFO.

---
 rtl/synch_fifo_pkg.sv | 25 ++
 rtl/fifo_ptr.sv | 58 +++++
 rtl/synch_fifo_prog.sv | 176 +++++++++++++++++
 tb/tb_synch_fifo_prog.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/synch_fifo_pkg.sv
// ----------------------------------------------------------------------------
// synch_fifo_pkg
//   Shared definitions for the programmable synchronous FIFO:
//   - output-mode constants selecting registered read or first-word-fall-through
//   - helpers for the wrap-aware pointer increment used by fifo_ptr
// ----------------------------------------------------------------------------
package synch_fifo_pkg;

    // Read-data path selection for the FWFT parameter of synch_fifo_prog.
    localparam int MODE_REG  = 0;  // registered read, one cycle of latency
    localparam int MODE_FWFT = 1;  // head word always presented on rdata_o

    // True when an index sits on the last slot of a DEPTH-entry ring, so the
    // next increment returns to 0 and flips the wrap bit.
    function automatic logic ptr_at_end(input int unsigned idx, input int unsigned depth);
        return (idx == depth - 1);
    endfunction

    // Next index in a DEPTH-entry ring. DEPTH need not be a power of two, so
    // the wrap is an explicit compare rather than natural binary rollover.
    function automatic int unsigned ptr_next_idx(input int unsigned idx, input int unsigned depth);
        return ptr_at_end(idx, depth) ? 0 : idx + 1;
    endfunction

endpackage : synch_fifo_pkg

// File: rtl/fifo_ptr.sv
// ----------------------------------------------------------------------------
// fifo_ptr
//   Ring-buffer pointer: an index in 0..DEPTH-1 plus a wrap bit that toggles
//   every time the index rolls over from DEPTH-1 to 0. Comparing two such
//   pointers distinguishes "same slot, same lap" (empty) from "same slot,
//   one lap apart" (full).
// Ports
//   clk_i   in   1          clock, rising edge
//   rst_ni  in   1          asynchronous active-low reset (index and wrap to 0)
//   inc_i   in   1          advance the pointer by one slot
//   idx_o   out  PTR_WIDTH  current index
//   wrap_o  out  1          current wrap bit
// ----------------------------------------------------------------------------
module fifo_ptr
    import synch_fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 inc_i,
    output logic [PTR_WIDTH-1:0] idx_o,
    output logic                 wrap_o
);

    logic [PTR_WIDTH-1:0] idx_q, idx_d;
    logic                 wrap_q, wrap_d;

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        idx_d  = idx_q;
        wrap_d = wrap_q;
        if (inc_i) begin
            idx_d = PTR_WIDTH'(ptr_next_idx(32'(idx_q), DEPTH));
            if (ptr_at_end(32'(idx_q), DEPTH)) begin
                wrap_d = ~wrap_q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
        end
    end

    assign idx_o  = idx_q;
    assign wrap_o = wrap_q;

endmodule : fifo_ptr

// File: rtl/synch_fifo_prog.sv
// ----------------------------------------------------------------------------
// synch_fifo_prog
//   Single-clock FIFO with fill-level count, programmable almost-full /
//   almost-empty flags and a build-time choice of registered-read (FWFT=0)
//   or first-word-fall-through (FWFT=1) output.
// Ports
//   clk_i           in   1           clock, rising edge
//   rst_ni          in   1           asynchronous active-low reset
//   wr_en_i         in   1           write request
//   wdata_i         in   DATA_WIDTH  write data
//   rd_en_i         in   1           read request (FWFT: pop of the head word)
//   rdata_o         out  DATA_WIDTH  read data
//   rvalid_o        out  1           FWFT=0: pulse after an accepted read
//                                    FWFT=1: head word present (!empty)
//   af_thresh_i     in   CNT_WIDTH   almost-full threshold
//   ae_thresh_i     in   CNT_WIDTH   almost-empty threshold
//   count_o         out  CNT_WIDTH   number of stored words
//   full_o          out  1           FIFO holds DEPTH words
//   empty_o         out  1           FIFO holds no words
//   almost_full_o   out  1           count_o >= af_thresh_i
//   almost_empty_o  out  1           count_o <= ae_thresh_i
//   overflow_o      out  1           one-cycle pulse: a write was rejected
//   underflow_o     out  1           one-cycle pulse: a read was rejected
// ----------------------------------------------------------------------------
module synch_fifo_prog
    import synch_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 16,
    parameter int FWFT       = MODE_REG,
    parameter int PTR_WIDTH  = $clog2(DEPTH),
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    input  logic [CNT_WIDTH-1:0]  af_thresh_i,
    input  logic [CNT_WIDTH-1:0]  ae_thresh_i,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    // ------------------------------------------------------------------
    // Pointers
    // ------------------------------------------------------------------
    logic [PTR_WIDTH-1:0] wr_idx, rd_idx;
    logic                 wr_wrap, rd_wrap;
    logic                 wr_acc, rd_acc;

    fifo_ptr #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_wr_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (wr_acc),
        .idx_o  (wr_idx),
        .wrap_o (wr_wrap)
    );

    fifo_ptr #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_rd_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (rd_acc),
        .idx_o  (rd_idx),
        .wrap_o (rd_wrap)
    );

    // Same slot: same lap means nothing stored, one lap apart means no room.
    logic empty, full;
    assign empty = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
    assign full  = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);

    // A read frees a slot in the same cycle, so a full FIFO can still take a
    // write when it is paired with a read.
    assign rd_acc = rd_en_i && !empty;
    assign wr_acc = wr_en_i && (!full || rd_acc);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; contents are only observable
    // behind the pointers, which are reset, and a reset array would cost a
    // reset net on every bit.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[wr_idx] <= wdata_i;
        end
    end

    // ------------------------------------------------------------------
    // Level count and error pulses
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    always_comb begin
        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
        ovf_d = wr_en_i && !wr_acc;
        unf_d = rd_en_i && empty;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // ------------------------------------------------------------------
    // Flags: combinational from registered state and live thresholds.
    // Thresholds above DEPTH naturally give af=0 and ae=1.
    // ------------------------------------------------------------------
    assign count_o        = count_q;
    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (count_q >= af_thresh_i);
    assign almost_empty_o = (count_q <= ae_thresh_i);
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

    // ------------------------------------------------------------------
    // Read-data path
    // ------------------------------------------------------------------
    if (FWFT == MODE_FWFT) begin : g_fwft
        // Head word is shown directly; forced to 0 while empty so the output
        // is defined during and after reset even though mem is not reset.
        assign rdata_o  = empty ? '0 : mem[rd_idx];
        assign rvalid_o = !empty;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] rdata_q;
        logic                  rvalid_q;

        // rdata_q holds its value between reads, including on underflow.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) begin
                    rdata_q <= mem[rd_idx];
                end
            end
        end

        assign rdata_o  = rdata_q;
        assign rvalid_o = rvalid_q;
    end

endmodule : synch_fifo_prog

// File: tb/tb_synch_fifo_prog.sv
// ----------------------------------------------------------------------------
// tb_synch_fifo_prog
//   Drives one registered-read and one FWFT instance with identical stimulus
//   and checks both against a queue-based model of the FIFO every cycle,
//   plus directed scenarios with literal expected values.
// ----------------------------------------------------------------------------
module tb_synch_fifo_prog;

    localparam int DW    = 12;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en, rd_en;
    logic [DW-1:0] wdata;
    logic [CW-1:0] af_th, ae_th;

    logic [DW-1:0] r_rdata, f_rdata;
    logic          r_rvalid, f_rvalid;
    logic [CW-1:0] r_count, f_count;
    logic          r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    synch_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) dut_reg (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_en_i(wr_en), .wdata_i(wdata), .rd_en_i(rd_en),
        .rdata_o(r_rdata), .rvalid_o(r_rvalid),
        .af_thresh_i(af_th), .ae_thresh_i(ae_th),
        .count_o(r_count), .full_o(r_full), .empty_o(r_empty),
        .almost_full_o(r_af), .almost_empty_o(r_ae),
        .overflow_o(r_ovf), .underflow_o(r_unf)
    );

    synch_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_en_i(wr_en), .wdata_i(wdata), .rd_en_i(rd_en),
        .rdata_o(f_rdata), .rvalid_o(f_rvalid),
        .af_thresh_i(af_th), .ae_thresh_i(ae_th),
        .count_o(f_count), .full_o(f_full), .empty_o(f_empty),
        .almost_full_o(f_af), .almost_empty_o(f_ae),
        .overflow_o(f_ovf), .underflow_o(f_unf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of stored words plus the last read result.
    // ------------------------------------------------------------------
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rdata;
    bit            m_rvalid, m_ovf, m_unf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_rdata  = '0;
            m_rvalid = 1'b0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
        end else begin : model_step
            bit ra, wa;
            int sz;
            sz = mq.size();
            ra = rd_en && (sz != 0);
            wa = wr_en && ((sz < DEPTH) || ra);
            m_ovf    = wr_en && !wa;
            m_unf    = rd_en && (sz == 0);
            m_rvalid = ra;
            if (ra) m_rdata = mq.pop_front();
            if (wa) mq.push_back(wdata);
        end
    end

    // Every-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin : compare
            int sz;
            logic [DW-1:0] head;
            sz   = mq.size();
            head = (sz != 0) ? mq[0] : '0;
            check("count_reg",  r_count, sz);
            check("count_fwft", f_count, sz);
            check("full_reg",   r_full,  sz == DEPTH);
            check("full_fwft",  f_full,  sz == DEPTH);
            check("empty_reg",  r_empty, sz == 0);
            check("empty_fwft", f_empty, sz == 0);
            check("af_reg",     r_af,    sz >= int'(af_th));
            check("af_fwft",    f_af,    sz >= int'(af_th));
            check("ae_reg",     r_ae,    sz <= int'(ae_th));
            check("ae_fwft",    f_ae,    sz <= int'(ae_th));
            check("ovf_reg",    r_ovf,   m_ovf);
            check("ovf_fwft",   f_ovf,   m_ovf);
            check("unf_reg",    r_unf,   m_unf);
            check("unf_fwft",   f_unf,   m_unf);
            check("rvalid_reg", r_rvalid, m_rvalid);
            check("rdata_reg",  r_rdata,  m_rdata);
            check("rvalid_fwft", f_rvalid, sz != 0);
            check("rdata_fwft",  f_rdata,  head);
        end
    end

    // One clock of stimulus: inputs set after a falling edge, held across the
    // rising edge, then released at the next falling edge.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
        wr_en = w;
        wdata = d;
        rd_en = r;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = '0;
        af_th = 5'd12;
        ae_th = 5'd3;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("init_count", r_count, 0);
        check("init_empty", r_empty, 1);
        check("init_ae",    r_ae,    1);

        // Reset mid-stream with five words stored and a read result held.
        for (int i = 1; i <= 6; i++) step(1'b1, DW'(i), 1'b0);
        step(1'b0, '0, 1'b1);
        check("pre_rst_count", r_count, 5);
        check("pre_rst_rdata", r_rdata, 12'h001);
        #2 rst_n = 1'b0;
        #1;
        check("rst_count",  r_count,  0);
        check("rst_empty",  r_empty,  1);
        check("rst_full",   r_full,   0);
        check("rst_ae",     r_ae,     1);
        check("rst_af",     r_af,     0);
        check("rst_ovf",    r_ovf,    0);
        check("rst_unf",    r_unf,    0);
        check("rst_rvalid", r_rvalid, 0);
        check("rst_rdata",  r_rdata,  0);
        check("rst_f_rvalid", f_rvalid, 0);
        check("rst_f_rdata",  f_rdata,  0);
        check("rst_f_count",  f_count,  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_count", r_count, 0);

        // Fill and drain in order.
        for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b0);
        check("fill_full",  r_full,  1);
        check("fill_count", r_count, 16);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, '0, 1'b1);
            check("drain_rdata",  r_rdata,  i);
            check("drain_rvalid", r_rvalid, 1);
        end
        check("drain_empty", r_empty, 1);

        // Underflow leaves the last read word in place.
        step(1'b0, '0, 1'b1);
        check("unf_pulse",  r_unf,    1);
        check("unf_rdata",  r_rdata,  12'h010);
        check("unf_rvalid", r_rvalid, 0);
        step(1'b0, '0, 1'b0);
        check("unf_clear", r_unf, 0);

        // Overflow when full with no read.
        for (int i = 1; i <= 16; i++) step(1'b1, DW'(12'h100 + i), 1'b0);
        step(1'b1, 12'h3FF, 1'b0);
        check("ovf_pulse", r_ovf,   1);
        check("ovf_count", r_count, 16);
        step(1'b0, '0, 1'b0);
        check("ovf_clear", r_ovf, 0);

        // Full with simultaneous read and write.
        step(1'b1, 12'hABC, 1'b1);
        check("rw_full_count", r_count, 16);
        check("rw_full_ovf",   r_ovf,   0);
        check("rw_full_rdata", r_rdata, 12'h101);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, '0, 1'b1);
            if (i == 15) check("rw_last_old", r_rdata, 12'h110);
            if (i == 16) check("rw_abc_out",  r_rdata, 12'hABC);
        end

        // Almost-full at 12, almost-empty at 3.
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, DW'(12'h200 + i), 1'b0);
            if (i == 11) check("af_below", r_af, 0);
            if (i == 12) check("af_at",    r_af, 1);
        end
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, '0, 1'b1);
            if (i == 8) check("ae_above", r_ae, 0);
            if (i == 9) check("ae_at",    r_ae, 1);
        end
        for (int i = 1; i <= 3; i++) step(1'b0, '0, 1'b1);

        // FWFT head word visible one cycle after the write, no read needed.
        step(1'b1, 12'h055, 1'b0);
        check("fwft_rvalid", f_rvalid, 1);
        check("fwft_rdata",  f_rdata,  12'h055);
        step(1'b0, '0, 1'b1);
        check("fwft_pop_rvalid", f_rvalid, 0);
        check("fwft_pop_reg",    r_rdata,  12'h055);

        // Thresholds beyond DEPTH.
        af_th = 5'd20;
        ae_th = 5'd20;
        for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b0);
        check("big_af", r_af, 0);
        check("big_ae", r_ae, 1);

        // Randomized mixed traffic with phases biased toward full and empty.
        for (int k = 0; k < 900; k++) begin
            int pw, pr;
            case ((k / 100) % 3)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 30; pr = 80; end
                default: begin pw = 60; pr = 60; end
            endcase
            if (k % 50 == 0) begin
                af_th = CW'($urandom_range(0, 20));
                ae_th = CW'($urandom_range(0, 20));
            end
            if (k == 450) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            step($urandom_range(0, 99) < pw, DW'($urandom), $urandom_range(0, 99) < pr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_synch_fifo_prog
